// File: rtl/systolic_array_output_fifo.sv
// rtl/systolic_array_output_fifo.sv - packs systolic array edge values into rows behind a two-row buffer (optional SA_OFIFO_OVERFLOW_EN sticky drop flag)
module systolic_array_output_fifo #(
    parameter int array_dim = 4,
    parameter int data_w    = 16
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          shift,
    input  logic [data_w-1:0]             shift_value,
    input  logic                          clear,
    input  logic                          row_ready,
    output logic                          row_valid,
    output logic [data_w*array_dim-1:0]   row_values,
    output logic                          full,
    output logic [$clog2(array_dim+1)-1:0] count,
    output logic                          overflow
);

    localparam int RW = data_w * array_dim;
    localparam int CW = $clog2(array_dim + 1);
    localparam logic [CW-1:0] C_FULL = CW'(array_dim);
    localparam logic [CW-1:0] C_LAST = CW'(array_dim - 1);

    logic [RW-1:0] r_a;
    logic [RW-1:0] r_h;
    logic [CW-1:0] r_count;
    logic          r_valid;

    logic          w_drain;
    logic          w_h_free;
    logic          w_full;
    logic [RW-1:0] w_packed;
    logic          w_load_h;
    logic [RW-1:0] w_h_next;
    logic          w_a_load;
    logic [CW-1:0] w_count_next;
    logic          w_valid_next;

    assign w_drain  = r_valid && row_ready;
    assign w_h_free = !r_valid || w_drain;
    assign w_full   = (r_count == C_FULL) && !row_ready;
    // Shifting left keeps the first value of a row in the MSB slice.
    assign w_packed = (r_a << data_w) | RW'(shift_value);

    // Decide what moves into the holding register and how the assembly counter advances.
    always_comb begin
        w_load_h     = 1'b0;
        w_h_next     = r_a;
        w_a_load     = 1'b0;
        w_count_next = r_count;
        if (r_count == C_FULL) begin
            // A parked row can only leave once the holding register frees up;
            // any shift in that cycle starts the next row.
            if (w_h_free) begin
                w_load_h     = 1'b1;
                w_h_next     = r_a;
                w_a_load     = shift;
                w_count_next = shift ? CW'(1) : '0;
            end
        end else if (shift) begin
            w_a_load = 1'b1;
            if (r_count == C_LAST) begin
                if (w_h_free) begin
                    w_load_h     = 1'b1;
                    w_h_next     = w_packed;
                    w_count_next = '0;
                end else begin
                    w_count_next = C_FULL;
                end
            end else begin
                w_count_next = r_count + CW'(1);
            end
        end
        w_valid_next = w_load_h ? 1'b1 : (w_drain ? 1'b0 : r_valid);
    end

    // Buffer state; clear outranks shift and drain.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_a     <= '0;
            r_h     <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_a_load) begin
                r_a <= w_packed;
            end
            if (w_load_h) begin
                r_h <= w_h_next;
            end
            r_count <= w_count_next;
            r_valid <= w_valid_next;
        end
    end

`ifdef SA_OFIFO_OVERFLOW_EN
    logic r_overflow;

    // Sticky record of any shift dropped while both rows were occupied.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (shift && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign row_valid  = r_valid;
    assign row_values = r_valid ? r_h : '0;
    assign full       = w_full;
    assign count      = r_count;

endmodule

// File: tb/tb_systolic_array_output_fifo.sv
// tb/tb_systolic_array_output_fifo.sv - randomized and directed check of systolic_array_output_fifo against a queue model
module tb_systolic_array_output_fifo;

    localparam int AD = 4;
    localparam int DW = 16;
    localparam int RW = AD * DW;
    localparam int CW = $clog2(AD + 1);

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          shift = 1'b0;
    logic [DW-1:0] shift_value = '0;
    logic          clear = 1'b0;
    logic          row_ready = 1'b0;
    logic          row_valid;
    logic [RW-1:0] row_values;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    systolic_array_output_fifo #(.array_dim(AD), .data_w(DW)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .shift      (shift),
        .shift_value(shift_value),
        .clear      (clear),
        .row_ready  (row_ready),
        .row_valid  (row_valid),
        .row_values (row_values),
        .full       (full),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: finished rows waiting for writeback (oldest first, at most two)
    // and the values of the row still being assembled.
    logic [RW-1:0] m_rows[$];
    logic [DW-1:0] m_part[$];
    bit            m_ov;

    function automatic logic [RW-1:0] pack_row(input logic [DW-1:0] v0, v1, v2, v3);
        return {v0, v1, v2, v3};
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_rows.delete();
            m_part.delete();
            m_ov = 0;
        end else if (clear) begin
            m_rows.delete();
            m_part.delete();
            m_ov = 0;
        end else begin
            bit m_drain, m_full;
            m_drain = (m_rows.size() > 0) && row_ready;
            m_full  = (m_rows.size() == 2) && !row_ready;
            if (shift && m_full) m_ov = 1;
            if (m_drain) void'(m_rows.pop_front());
            if (shift && !m_full) begin
                m_part.push_back(shift_value);
                if (m_part.size() == AD) begin
                    m_rows.push_back(pack_row(m_part[0], m_part[1], m_part[2], m_part[3]));
                    m_part.delete();
                end
            end
        end
    end

    // Every cycle out of reset, DUT outputs must match what the model says.
    always @(negedge CLK) begin
        if (nRST) begin
            logic [RW-1:0] e_vals;
            logic [CW-1:0] e_cnt;
            logic          e_ov;
            e_vals = (m_rows.size() > 0) ? m_rows[0] : '0;
            e_cnt  = (m_rows.size() == 2) ? CW'(AD) : CW'(m_part.size());
`ifdef SA_OFIFO_OVERFLOW_EN
            e_ov = m_ov;
`else
            e_ov = 1'b0;
`endif
            chk("row_valid", RW'(row_valid), RW'(m_rows.size() > 0));
            chk("row_values", row_values, e_vals);
            chk("full", RW'(full), RW'((m_rows.size() == 2) && !row_ready));
            chk("count", RW'(count), RW'(e_cnt));
            chk("overflow", RW'(overflow), RW'(e_ov));
        end
    end

    // Rows actually handed to writeback by the DUT.
    logic [RW-1:0] dut_rows[$];
    always @(negedge CLK) begin
        if (nRST && !clear && row_valid && row_ready) dut_rows.push_back(row_values);
    end

    task automatic cyc(input logic sh, input logic [DW-1:0] v, input logic rdy, input logic clr);
        shift       = sh;
        shift_value = v;
        row_ready   = rdy;
        clear       = clr;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [RW-1:0] last_row(input int back);
        if (dut_rows.size() > back) return dut_rows[dut_rows.size() - 1 - back];
        return 'x;
    endfunction

    initial begin
        int base;
        logic [RW-1:0] v;

        // Reset state.
        #12;
        chk("rst_row_valid", RW'(row_valid), '0);
        chk("rst_row_values", row_values, '0);
        chk("rst_count", RW'(count), '0);
        chk("rst_full", RW'(full), '0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        cyc(0, 0, 1, 0);

        // Single row.
        cyc(1, 16'h1111, 1, 0);
        cyc(1, 16'h2222, 1, 0);
        cyc(1, 16'h3333, 1, 0);
        cyc(1, 16'h4444, 1, 0);
        chk("single_valid", RW'(row_valid), RW'(1));
        v = 64'h1111_2222_3333_4444;
        chk("single_values", row_values, v);
        cyc(0, 0, 1, 0);
        chk("single_valid_drop", RW'(row_valid), '0);

        // Streaming 12 values.
        base = dut_rows.size();
        for (int i = 0; i < 12; i++) cyc(1, DW'(16'h0100 + i), 1, 0);
        cyc(0, 0, 1, 0);
        chk("stream_rows", RW'(dut_rows.size() - base), RW'(3));
        v = 64'h0100_0101_0102_0103;
        chk("stream_row0", last_row(2), v);
        v = 64'h0108_0109_010A_010B;
        chk("stream_row2", last_row(0), v);

        // Backpressure and overflow.
        cyc(0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) cyc(1, DW'(i), 0, 0);
        chk("bp_full", RW'(full), RW'(1));
        chk("bp_count", RW'(count), RW'(AD));
        cyc(1, 16'h0009, 0, 0);
`ifdef SA_OFIFO_OVERFLOW_EN
        chk("bp_overflow", RW'(overflow), RW'(1));
`else
        chk("bp_overflow", RW'(overflow), '0);
`endif
        base = dut_rows.size();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("bp_rows", RW'(dut_rows.size() - base), RW'(2));
        v = 64'h0001_0002_0003_0004;
        chk("bp_row0", last_row(1), v);
        v = 64'h0005_0006_0007_0008;
        chk("bp_row1", last_row(0), v);
        chk("bp_empty", RW'(row_valid), '0);

        // Drain and shift together while full.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, DW'(16'hB001 + i), 0, 0);
        cyc(1, 16'hAAAA, 1, 0);
        chk("ds_count", RW'(count), RW'(1));
        chk("ds_valid", RW'(row_valid), RW'(1));
        v = 64'hB005_B006_B007_B008;
        chk("ds_h", row_values, v);
        cyc(1, 16'hBBBB, 1, 0);
        cyc(1, 16'hCCCC, 1, 0);
        cyc(1, 16'hDDDD, 1, 0);
        v = 64'hAAAA_BBBB_CCCC_DDDD;
        chk("ds_next_row", row_values, v);

        // Clear mid-row.
        cyc(0, 0, 1, 1);
        cyc(1, 16'h0001, 1, 0);
        cyc(1, 16'h0002, 1, 0);
        cyc(1, 16'h0099, 1, 1);
        chk("clr_count", RW'(count), '0);
        chk("clr_valid", RW'(row_valid), '0);
        for (int i = 5; i <= 8; i++) cyc(1, DW'(i), 1, 0);
        v = 64'h0005_0006_0007_0008;
        chk("clr_row", row_values, v);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 8, DW'($urandom), $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 2);
            if (i == 1500) begin
                #2;
                nRST = 1'b0;
                #1;
                chk("async_rst_valid", RW'(row_valid), '0);
                chk("async_rst_values", row_values, '0);
                chk("async_rst_count", RW'(count), '0);
                chk("async_rst_full", RW'(full), '0);
                chk("async_rst_overflow", RW'(overflow), '0);
                @(posedge CLK); #1;
                nRST = 1'b1;
            end
        end
        cyc(0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
